// File: rtl/modport_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit binary pointers.
// The flags are registered from the next-state pointers, so they are valid right after each clock edge.
module modport_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty
);

  logic [DSIZE-1:0] mem [2**ASIZE];

  logic [ASIZE:0] wptr_reg, wptr_next;
  logic [ASIZE:0] rptr_reg, rptr_next;
  logic           wfull_reg, wfull_next;
  logic           rempty_reg, rempty_next;
  logic           write_en, read_en;

  // Gating on the registered flags drops the write when the FIFO is full and drops the read when it is empty.
  assign write_en = winc & ~wfull_reg;
  assign read_en  = rinc & ~rempty_reg;

  always_comb begin
    wptr_next   = wptr_reg;
    rptr_next   = rptr_reg;
    if (write_en) wptr_next = wptr_reg + 1'b1;
    if (read_en)  rptr_next = rptr_reg + 1'b1;
    rempty_next = (wptr_next == rptr_next);
    wfull_next  = (wptr_next[ASIZE] != rptr_next[ASIZE]) &&
                  (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_reg   <= '0;
      rptr_reg   <= '0;
      wfull_reg  <= 1'b0;
      rempty_reg <= 1'b1;
    end else begin
      wptr_reg   <= wptr_next;
      rptr_reg   <= rptr_next;
      wfull_reg  <= wfull_next;
      rempty_reg <= rempty_next;
    end
  end

  // The storage array is not reset; after a reset, stale words cannot be reached through the pointers.
  always_ff @(posedge wclk) begin
    if (write_en) mem[wptr_reg[ASIZE-1:0]] <= wdata;
  end

  assign rdata  = mem[rptr_reg[ASIZE-1:0]];
  assign wfull  = wfull_reg;
  assign rempty = rempty_reg;

endmodule

// File: tb/tb_modport_fifo.sv
// Directed testbench for modport_fifo (depth 16, 8-bit data).
// Expected values are computed by hand and checked with immediate assertions.
module tb_modport_fifo;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b1;
  logic [7:0] wdata = '0;
  logic       winc = 1'b0;
  logic       wfull;
  logic       rinc = 1'b0;
  logic [7:0] rdata;
  logic       rempty;

  int errors = 0;
  int checks = 0;

  modport_fifo #(.DSIZE(8), .ASIZE(4)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wdata  (wdata),
    .winc   (winc),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock cycle of requests, then sample the outputs 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge wclk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
    $display("t=%0t winc=%b rinc=%b wdata=%02h -> rdata=%02h rempty=%b wfull=%b",
             $time, w, r, d, rdata, rempty, wfull);
  endtask

  initial begin
    // Assert reset asynchronously, before any clock edge.
    #2 wrst_n = 1'b0;
    #1;
    check("reset_rempty", rempty, 1);
    check("reset_wfull", wfull, 0);
    @(posedge wclk); #1;
    wrst_n = 1'b1;

    // With no requests, the flags must stay idle.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00);
      check("idle_rempty", rempty, 1);
      check("idle_wfull", wfull, 0);
    end

    // Fill the FIFO with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 8'(i));
      check("fill_rempty", rempty, 0);
      check("fill_wfull", wfull, (i == 16) ? 1 : 0);
      check("fill_head", rdata, 8'h01);
    end
    // A write while full must be ignored.
    step(1, 0, 8'hFF);
    check("over_wfull", wfull, 1);
    check("over_head", rdata, 8'h01);

    // Drain the FIFO; data must come out in write order.
    for (int i = 1; i <= 16; i++) begin
      check("drain_data", rdata, 8'(i));
      step(0, 1, 8'h00);
      check("drain_wfull", wfull, 0);
      check("drain_rempty", rempty, (i == 16) ? 1 : 0);
    end
    // A read while empty must be ignored.
    step(0, 1, 8'h00);
    check("under_rempty", rempty, 1);
    check("under_wfull", wfull, 0);

    // Write and read together while empty: the write wins.
    step(1, 1, 8'hA5);
    check("empty_both_rempty", rempty, 0);
    check("empty_both_rdata", rdata, 8'hA5);
    check("empty_both_wfull", wfull, 0);

    // Simultaneous push and pop with one word stored: the head advances to each new word.
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 8'(8'h20 + i));
      check("stream_rdata", rdata, 8'(8'h20 + i));
      check("stream_rempty", rempty, 0);
      check("stream_wfull", wfull, 0);
    end

    // Top up to full. The head is 0x47; add 15 more words.
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 8'(8'h50 + i));
      check("topup_wfull", wfull, (i == 14) ? 1 : 0);
    end
    check("topup_head", rdata, 8'h47);
    // Write and read together while full: the read wins and the new word is dropped.
    step(1, 1, 8'hEE);
    check("full_both_wfull", wfull, 0);
    check("full_both_rdata", rdata, 8'h50);
    // Occupancy is now 15, so one more write fills the FIFO.
    step(1, 0, 8'h77);
    check("full_both_refill", wfull, 1);

    // Start from a clean reset, store 5 words, then reset mid-cycle.
    wrst_n = 1'b0;
    #1;
    check("reset2_rempty", rempty, 1);
    check("reset2_wfull", wfull, 0);
    wrst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h30 + i));
    check("five_rdata", rdata, 8'h30);
    check("five_rempty", rempty, 0);
    #3 wrst_n = 1'b0;
    #1;
    check("async_rempty", rempty, 1);
    check("async_wfull", wfull, 0);
    @(posedge wclk); #1;
    check("async_hold_rempty", rempty, 1);
    wrst_n = 1'b1;
    step(1, 0, 8'h99);
    check("post_reset_rdata", rdata, 8'h99);
    check("post_reset_rempty", rempty, 0);
    step(0, 1, 8'h00);
    check("post_reset_empty", rempty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modport_fifo.md
MODPORT_FIFO -- requirements
Module: modport_fifo

Interface
REQ-001 Parameter DSIZE, default 8, data word width in bits.
REQ-002 Parameter ASIZE, default 4, address width; depth = 2**ASIZE (16 words by default).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; ports named wclk and wrst_n as in the codebase.
REQ-004 wclk  input  1  sole clock; all state updates on posedge.
REQ-005 wrst_n  input  1  asynchronous active-low reset.
REQ-006 wdata  input  DSIZE  write data, sampled on posedge wclk when a write is accepted.
REQ-007 winc  input  1  write request.
REQ-008 wfull  output  1  FIFO full flag.
REQ-009 rinc  input  1  read request (pop).
REQ-010 rdata  output  DSIZE  head-of-FIFO data (show-ahead).
REQ-011 rempty  output  1  FIFO empty flag.

Function
REQ-012 Storage SHALL be a 2**ASIZE x DSIZE register array; it is not reset.
REQ-013 Write and read pointers SHALL be ASIZE+1-bit binary counters; the low ASIZE bits address memory, the MSB is the wrap bit.
REQ-014 Write accepted = winc & ~wfull: mem[wptr[ASIZE-1:0]] <= wdata, wptr <= wptr+1 (modulo 2**(ASIZE+1)).
REQ-015 Read accepted = rinc & ~rempty: rptr <= rptr+1; no other side effect.
REQ-016 winc while wfull SHALL be ignored: no memory write, no pointer change, no error output.
REQ-017 rinc while rempty SHALL be ignored: no pointer change.
REQ-018 rdata SHALL be combinational mem[rptr[ASIZE-1:0]], valid whenever rempty=0; its value while rempty=1 is unspecified and checkers ignore it.
REQ-019 rempty and wfull SHALL be registered and computed from next-state pointers, so they are correct immediately after every posedge (zero-cycle flag latency).
REQ-020 rempty = 1 iff next wptr == next rptr (all ASIZE+1 bits).
REQ-021 wfull = 1 iff the next pointers differ in the MSB and are equal in the low ASIZE bits.
REQ-022 Simultaneous accepted write and read SHALL leave the occupancy unchanged and flags unchanged.
REQ-023 Write and read both requested while full: the read is accepted and the write is dropped; after the edge wfull=0 and occupancy = depth-1.
REQ-024 Write and read both requested while empty: the write is accepted and the read is dropped; after the edge rempty=0 and rdata shows the written word.
REQ-025 Data SHALL emerge in strict write order across any number of pointer wrap-arounds.

Reset
REQ-026 While wrst_n=0: wptr=0, rptr=0, rempty=1, wfull=0, asynchronously and independent of wclk.
REQ-027 Reset asserted mid-operation SHALL discard all contents immediately; memory values are not cleared but are unreachable.
REQ-028 After wrst_n rises, the first posedge SHALL accept operations normally.

Verification
REQ-029 Reset, then no requests -> rempty=1, wfull=0 every cycle.
REQ-030 Write 0x01..0x10 on 16 consecutive cycles (depth 16) -> rempty=0 after the 1st edge, wfull=1 after the 16th; a 17th write of 0xFF is ignored.
REQ-031 From full, read 16 times -> rdata sequence 0x01..0x10, wfull=0 after the 1st read, rempty=1 after the 16th; a further rinc is ignored.
REQ-032 Continuous simultaneous winc/rinc for 40 cycles, starting with 1 word stored -> occupancy stays 1, in-order data, wrap-around passed twice.
REQ-033 Full with winc=rinc=1 -> head word popped, new word dropped, wfull=0; empty with winc=rinc=1 -> word stored, rempty=0, rdata = written value.
REQ-034 Assert wrst_n=0 asynchronously with 5 words stored -> rempty=1 and wfull=0 without waiting for a clock edge; the next write/read returns the new word only.
